uart_tx: RTL and testbench

Byte-wide UART transmitter that serialises bytes onto `usb_tx` at a fixed baud rate, with a valid/ready handshake on the byte side. It sits between board-level logic (command responder, debug printer) and the FTDI USB-serial pin. It replaces the current direct `usb_rx`→`usb_tx` loopback as the driver of `usb_tx`, and is the transmit counterpart of the planned `uart_rx`.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and the future UART receiver:
//   parity_t    - parity mode selection (none / even / odd)
//   tx_state_t  - transmitter frame state encoding
//   clks_per_bit(clk_freq, baud) - clock cycles per bit, rounded to nearest
// ---------------------------------------------------------------------------
package uart_pkg;

    // Parity mode of a frame; PAR_NONE omits the parity bit entirely.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    // Transmitter states. The TX_ prefix keeps these literals from clashing
    // with the PARITY parameter and with receiver state names later on.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Bit period in clock cycles, rounded to the nearest integer so that the
    // baud error stays within half a clock per bit.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Byte-wide UART transmitter. Accepts a byte on a valid/ready handshake and
// serialises it as: start bit (0), data bits LSB first, optional parity bit,
// then STOP_BITS stop bits (1). The line idles high.
//
// Parameters:
//   CLK_FREQ  - clk frequency in Hz
//   BAUD      - line rate in bit/s
//   PARITY    - PAR_NONE / PAR_EVEN / PAR_ODD
//   STOP_BITS - 1 or 2
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   in_data   - byte to send
//   in_valid  - in_data is presented
//   in_ready  - a byte is accepted this cycle when in_valid is also high
//   block     - holds off new frames (ignored once a frame has started)
//   tx        - registered serial output
//   busy      - a frame is in progress
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int      CLK_FREQ  = 100_000_000,
    parameter int      BAUD      = 1_000_000,
    parameter parity_t PARITY    = PAR_NONE,
    parameter int      STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       block,
    output logic       tx,
    output logic       busy
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    // Reject configurations the counters cannot represent.
    generate
        if (CPB < 2) begin : g_bad_cpb
            $error("uart_tx: CLK_FREQ/BAUD gives fewer than 2 clocks per bit");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
            $error("uart_tx: illegal PARITY setting");
        end
    endgenerate

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             bit_done;

    assign bit_done = (baud_q == CNT_LAST);
    assign in_ready = (state_q == TX_IDLE) && !block;
    assign busy     = (state_q != TX_IDLE);
    assign tx       = tx_q;

    // Next-state logic. tx_d always carries the line level of the state being
    // entered, so the registered tx lines up exactly with the state register.
    // The shift register moves right once per data bit, which puts the next
    // bit to send in shift_q[1] at each data bit boundary.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tx_d       = tx_q;

        case (state_q)
            TX_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (in_valid && in_ready) begin
                    state_d    = TX_START;
                    shift_d    = in_data;
                    par_d      = (PARITY == PAR_ODD) ? ~^in_data : ^in_data;
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                end
            end

            TX_START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = TX_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            TX_DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY == PAR_NONE) begin
                            state_d = TX_STOP;
                            tx_d    = 1'b1;
                        end else begin
                            state_d = TX_PARITY;
                            tx_d    = par_q;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            TX_PARITY: begin
                if (bit_done) begin
                    baud_d     = '0;
                    state_d    = TX_STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            TX_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    baud_d = '0;
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = TX_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = TX_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State register. Reset drops any partially sent byte and forces the
    // line high on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. Four instances cover no parity, even
// parity, odd parity and two stop bits, all at 100 clocks per bit. Accepted
// bytes go into a scoreboard queue; the line monitor pops them when a start
// bit appears and checks every bit's level and duration.
// ---------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB  = 100;
    localparam int NDUT = 4;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         t_acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [3:0] valid_w, ready_w, block_w, tx_w, busy_w;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       sb_q[$];
    parity_t    par_cfg [NDUT];
    int         stop_cfg [NDUT];

    // 10-unit clock and a free-running cycle counter used for timing checks.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_none (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_w[0]), .in_ready(ready_w[0]),
        .block(block_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

    uart_tx #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_w[1]), .in_ready(ready_w[1]),
        .block(block_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

    uart_tx #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .PARITY(PAR_ODD), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_w[2]), .in_ready(ready_w[2]),
        .block(block_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

    uart_tx #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_stop2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_w[3]), .in_ready(ready_w[3]),
        .block(block_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference line level for frame bit b (0 = start bit).
    function automatic logic exp_bit(input int b, input logic [7:0] d, input parity_t par);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && par == PAR_EVEN) return ^d;
        if (b == 9 && par == PAR_ODD) return ~^d;
        return 1'b1;
    endfunction

    // Present a byte to instance idx and wait for it to be taken. The accept
    // cycle is recorded in the scoreboard. With hold=1 valid stays high.
    task automatic applyStimulus(input int idx, input logic [7:0] b, input bit hold);
        int wait_cnt;
        wait_cnt = 0;
        @(negedge clk);
        in_data      = b;
        valid_w[idx] = 1'b1;
        while (ready_w[idx] !== 1'b1 && wait_cnt < 5000) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (ready_w[idx] !== 1'b1) begin
            checkOutput("acceptTimeout", ready_w[idx], 1);
            valid_w[idx] = 1'b0;
            return;
        end
        sb_q.push_back('{idx: idx, data: b, t_acc: cyc});
        @(negedge clk);
        if (!hold) valid_w[idx] = 1'b0;
    endtask

    // Wait for a start bit on instance idx, pop the expected byte and check
    // the whole frame: first, middle and last cycle of every bit, the decoded
    // byte, and the handshake state as the frame ends.
    task automatic checkFrame(input int idx, output int s_out);
        exp_t       e;
        int         nb, wait_cnt, s, tgt;
        logic [7:0] rx;
        s_out    = -1;
        nb       = 9 + ((par_cfg[idx] != PAR_NONE) ? 1 : 0) + stop_cfg[idx];
        wait_cnt = 0;
        @(negedge clk);
        while (tx_w[idx] !== 1'b0 && wait_cnt < 20000) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (tx_w[idx] !== 1'b0) begin
            checkOutput("startTimeout", tx_w[idx], 0);
            return;
        end
        s     = cyc;
        s_out = s;
        if (sb_q.size() == 0) begin
            checkOutput("unexpectedFrame", sb_q.size(), 1);
            return;
        end
        e = sb_q.pop_front();
        checkOutput($sformatf("d%0d startLatency", idx), s - e.t_acc, 1);
        checkOutput($sformatf("d%0d busyAtStart", idx), busy_w[idx], 1);
        checkOutput($sformatf("d%0d readyAtStart", idx), ready_w[idx], 0);
        rx = 8'd0;
        for (int b = 0; b < nb; b++) begin
            tgt = s + b * CPB;
            while (cyc < tgt) @(negedge clk);
            checkOutput($sformatf("d%0d bit%0d first", idx, b), tx_w[idx], exp_bit(b, e.data, par_cfg[idx]));
            tgt = tgt + CPB / 2;
            while (cyc < tgt) @(negedge clk);
            checkOutput($sformatf("d%0d bit%0d mid", idx, b), tx_w[idx], exp_bit(b, e.data, par_cfg[idx]));
            if (b >= 1 && b <= 8) rx[b-1] = tx_w[idx];
            tgt = s + b * CPB + CPB - 1;
            while (cyc < tgt) @(negedge clk);
            checkOutput($sformatf("d%0d bit%0d last", idx, b), tx_w[idx], exp_bit(b, e.data, par_cfg[idx]));
        end
        checkOutput($sformatf("d%0d rxByte", idx), rx, e.data);
        checkOutput($sformatf("d%0d busyLastCycle", idx), busy_w[idx], 1);
        @(negedge clk);
        checkOutput($sformatf("d%0d busyAfter", idx), busy_w[idx], 0);
        checkOutput($sformatf("d%0d readyAfter", idx), ready_w[idx], !block_w[idx]);
        checkOutput($sformatf("d%0d txIdle", idx), tx_w[idx], 1);
    endtask

    // Hard stop in case anything above fails to terminate.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: cycle=%0d exceeded limit", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s1, s2, tgt, low_seen, blk_err;
        par_cfg[0] = PAR_NONE; stop_cfg[0] = 1;
        par_cfg[1] = PAR_EVEN; stop_cfg[1] = 1;
        par_cfg[2] = PAR_ODD;  stop_cfg[2] = 1;
        par_cfg[3] = PAR_NONE; stop_cfg[3] = 2;

        // Reset values, with block both high and low.
        rst     = 1'b1;
        in_data = 8'h00;
        valid_w = 4'b0000;
        block_w = 4'b0001;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("d%0d resetTx", i), tx_w[i], 1);
            checkOutput($sformatf("d%0d resetBusy", i), busy_w[i], 0);
        end
        checkOutput("resetReadyBlocked", ready_w[0], 0);
        block_w = 4'b0000;
        #1;
        checkOutput("resetReadyFree", ready_w[0], 1);
        rst = 1'b0;

        // Basic frame.
        $display("[TB] basic frame 0x55");
        fork
            applyStimulus(0, 8'h55, 1'b0);
            checkFrame(0, s1);
        join

        // Parity variants.
        $display("[TB] parity frames");
        fork applyStimulus(1, 8'h03, 1'b0); checkFrame(1, s1); join
        fork applyStimulus(2, 8'h03, 1'b0); checkFrame(2, s1); join
        fork applyStimulus(1, 8'hB7, 1'b0); checkFrame(1, s1); join
        fork applyStimulus(2, 8'h00, 1'b0); checkFrame(2, s1); join

        // Two stop bits, back-to-back.
        $display("[TB] two stop bits");
        fork
            begin
                applyStimulus(3, 8'hFF, 1'b1);
                applyStimulus(3, 8'h00, 1'b0);
            end
            begin
                checkFrame(3, s1);
                checkFrame(3, s2);
            end
        join
        checkOutput("stop2Spacing", s2 - s1, 11 * CPB + 1);

        // Back-to-back with valid held and in_data changed mid-frame.
        $display("[TB] back-to-back 0xA5 0x3C");
        fork
            begin
                applyStimulus(0, 8'hA5, 1'b1);
                applyStimulus(0, 8'h3C, 1'b1);
                valid_w[0] = 1'b0;
                in_data    = 8'hFF;
            end
            begin
                checkFrame(0, s1);
                checkFrame(0, s2);
            end
        join
        checkOutput("b2bSpacing", s2 - s1, 10 * CPB + 1);

        // Reset during data bit 4 (a low bit of 0xC3).
        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'hC3, 1'b0);
        s1  = cyc;
        tgt = s1 + 5 * CPB + 40;
        while (cyc < tgt) @(negedge clk);
        checkOutput("preResetTx", tx_w[0], 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midResetTx", tx_w[0], 1);
        checkOutput("midResetBusy", busy_w[0], 0);
        checkOutput("midResetReady", ready_w[0], 1);
        low_seen = 0;
        repeat (1500) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) low_seen = 1;
        end
        checkOutput("noGlitchAfterReset", low_seen, 0);
        if (sb_q.size() > 0) sb_q.delete(0);
        fork applyStimulus(0, 8'h5A, 1'b0); checkFrame(0, s1); join

        // Block: no activity while held, accept on release, mid-frame block ignored.
        $display("[TB] block");
        block_w[0] = 1'b1;
        in_data    = 8'h81;
        valid_w[0] = 1'b1;
        blk_err    = 0;
        repeat (500) begin
            @(negedge clk);
            if (ready_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) blk_err++;
        end
        checkOutput("blockHold", blk_err, 0);
        fork
            checkFrame(0, s1);
            begin
                int tgt2;
                @(negedge clk);
                block_w[0] = 1'b0;
                sb_q.push_back('{idx: 0, data: 8'h81, t_acc: cyc});
                #1;
                checkOutput("readyOnRelease", ready_w[0], 1);
                @(negedge clk);
                valid_w[0] = 1'b0;
                tgt2 = cyc + 300;
                while (cyc < tgt2) @(negedge clk);
                block_w[0] = 1'b1;
            end
        join
        block_w[0] = 1'b0;
        #1;
        checkOutput("readyAfterUnblock", ready_w[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
